// File: rtl/mac_tile_dm_if.sv
// Tile-to-tile bus for mac_tile_dm: west/north inputs and east/south registered outputs.
interface mac_tile_dm_if #(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16
);
  logic [bw-1:0]      in_w;
  logic [bw-1:0]      out_e;
  logic [2:0]         inst_w;
  logic [2:0]         inst_e;
  logic               mode_w;
  logic               mode_e;
  logic [psum_bw-1:0] in_n;
  logic               valid_n;
  logic [psum_bw-1:0] out_s;
  logic               valid_s;

  modport master (
    output in_w, inst_w, mode_w, in_n, valid_n,
    input  out_e, inst_e, mode_e, out_s, valid_s
  );

  modport slave (
    input  in_w, inst_w, mode_w, in_n, valid_n,
    output out_e, inst_e, mode_e, out_s, valid_s
  );
endinterface

// File: rtl/mac_tile_dm.sv
// Dual-mode (weight-/output-stationary) systolic MAC tile with OS drain chain
// and optional saturating accumulation.
module mac_tile_dm #(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter bit          SAT     = 1'b0
) (
  input logic          clk,
  input logic          reset,
  mac_tile_dm_if.slave tile
);
  typedef enum logic [1:0] {EMPTY, WLOAD, OSACC, OSDRAIN} state_t;

  localparam int unsigned PROD_W = 2 * bw + 1;
  localparam int unsigned SUM_W  = psum_bw + 1;
  localparam logic [psum_bw-1:0] PSUM_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] PSUM_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  // Unsigned activation times signed weight, sign-extended to the psum width.
  function automatic logic [psum_bw-1:0] prod(input logic [bw-1:0] act,
                                                input logic [bw-1:0] wgt);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'($signed({1'b0, act})) * PROD_W'($signed(wgt));
    return psum_bw'(p);
  endfunction

  // One guard bit catches signed overflow; clamp or wrap depending on SAT.
  function automatic logic [psum_bw-1:0] add_sat(input logic [psum_bw-1:0] x,
                                                   input logic [psum_bw-1:0] y);
    logic [SUM_W-1:0] s;
    s = SUM_W'($signed(x)) + SUM_W'($signed(y));
    if (SAT && (s[psum_bw] != s[psum_bw-1]))
      return s[psum_bw] ? PSUM_MIN : PSUM_MAX;
    return s[psum_bw-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [bw-1:0]      a_q, a_d;
  logic [bw-1:0]      b_q, b_d;
  logic [psum_bw-1:0] acc_q, acc_d;
  logic [2:0]         inst_q, inst_d;
  logic               mode_q, mode_d;
  logic [psum_bw-1:0] out_s_q, out_s_d;
  logic               valid_s_q, valid_s_d;
  logic               os_mode;
  logic [bw-1:0]      wgt_n;

  assign wgt_n = tile.in_n[bw-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      inst_q    <= '0;
      mode_q    <= 1'b0;
      out_s_q   <= '0;
      valid_s_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      inst_q    <= inst_d;
      mode_q    <= mode_d;
      out_s_q   <= out_s_d;
      valid_s_q <= valid_s_d;
    end
  end

  // Priority within each state: drain, then execute, then load.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    acc_d     = acc_q;
    out_s_d   = out_s_q;
    valid_s_d = 1'b0;
    a_d       = (tile.inst_w[0] || tile.inst_w[1]) ? tile.in_w : a_q;
    inst_d    = tile.inst_w;
    os_mode   = (state_q == EMPTY) ? tile.mode_w : mode_q;
    mode_d    = os_mode;

    case (state_q)
      EMPTY: begin
        // The first WS weight is consumed here, so its load bit is not forwarded.
        if (!os_mode) inst_d[0] = 1'b0;
        if (tile.inst_w[2]) begin
          out_s_d   = tile.in_n;
          valid_s_d = tile.valid_n;
        end else if (tile.inst_w[1]) begin
          if (os_mode) begin
            acc_d   = prod(tile.in_w, wgt_n);
            out_s_d = psum_bw'($signed(wgt_n));
            state_d = OSACC;
          end else begin
            out_s_d   = add_sat(prod(tile.in_w, b_q), tile.in_n);
            valid_s_d = 1'b1;
          end
        end else if (tile.inst_w[0] && !os_mode) begin
          b_d     = tile.in_w;
          state_d = WLOAD;
        end
      end
      WLOAD: begin
        if (tile.inst_w[2]) begin
          b_d       = '0;
          out_s_d   = tile.in_n;
          valid_s_d = tile.valid_n;
          state_d   = EMPTY;
        end else if (tile.inst_w[1]) begin
          out_s_d   = add_sat(prod(tile.in_w, b_q), tile.in_n);
          valid_s_d = 1'b1;
        end
      end
      OSACC: begin
        if (tile.inst_w[2]) begin
          out_s_d   = acc_q;
          valid_s_d = 1'b1;
          acc_d     = '0;
          state_d   = OSDRAIN;
        end else if (tile.inst_w[1]) begin
          acc_d   = add_sat(acc_q, prod(tile.in_w, wgt_n));
          out_s_d = psum_bw'($signed(wgt_n));
        end
      end
      OSDRAIN: begin
        if (tile.inst_w[2]) begin
          out_s_d   = tile.in_n;
          valid_s_d = tile.valid_n;
        end else begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign tile.out_e   = a_q;
  assign tile.inst_e  = inst_q;
  assign tile.mode_e  = mode_q;
  assign tile.out_s   = out_s_q;
  assign tile.valid_s = valid_s_q;
endmodule

// File: tb/tb_mac_tile_dm.sv
// Directed bench for mac_tile_dm: WS/OS dataflows, drain chain, mode lock, reset, saturation.
module tb_mac_tile_dm;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mac_tile_dm_if #(.bw(4), .psum_bw(16)) d ();
  mac_tile_dm_if #(.bw(4), .psum_bw(8))  s1 ();
  mac_tile_dm_if #(.bw(4), .psum_bw(8))  s0 ();

  mac_tile_dm #(.bw(4), .psum_bw(16), .SAT(1'b0)) u_dut   (.clk(clk), .reset(reset), .tile(d));
  mac_tile_dm #(.bw(4), .psum_bw(8),  .SAT(1'b1)) u_sat1  (.clk(clk), .reset(reset), .tile(s1));
  mac_tile_dm #(.bw(4), .psum_bw(8),  .SAT(1'b0)) u_sat0  (.clk(clk), .reset(reset), .tile(s0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drv(input logic [2:0] inst, input logic [3:0] a, input logic [15:0] n,
                     input logic md, input logic vn);
    d.inst_w = inst; d.in_w = a; d.in_n = n; d.mode_w = md; d.valid_n = vn;
  endtask

  task automatic drs(input logic [2:0] inst, input logic [3:0] a, input logic [7:0] n);
    s1.inst_w = inst; s1.in_w = a; s1.in_n = n;
    s0.inst_w = inst; s0.in_w = a; s0.in_n = n;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(3'b000, 4'h0, 16'h0, 1'b0, 1'b0);
    drs(3'b000, 4'h0, 8'h0);
    s1.mode_w = 1'b0; s1.valid_n = 1'b0;
    s0.mode_w = 1'b0; s0.valid_n = 1'b0;
    #1 reset = 1'b0;
    #6;
    tests++; if (d.out_s !== 16'h0) begin fails++; $display("FAIL reset_out_s: got %h want 0000", d.out_s); end
    tests++; if (d.valid_s !== 1'b0) begin fails++; $display("FAIL reset_valid_s: got %b want 0", d.valid_s); end
    tests++; if (d.out_e !== 4'h0) begin fails++; $display("FAIL reset_out_e: got %h want 0", d.out_e); end
    tests++; if (d.inst_e !== 3'b000) begin fails++; $display("FAIL reset_inst_e: got %b want 000", d.inst_e); end
    tests++; if (d.mode_e !== 1'b0) begin fails++; $display("FAIL reset_mode_e: got %b want 0", d.mode_e); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_ws_load();
    drv(3'b001, 4'h2, 16'h0, 1'b0, 1'b0); cyc();
    tests++; if (d.inst_e !== 3'b000) begin fails++; $display("FAIL load1_inst_e: got %b want 000", d.inst_e); end
    tests++; if (d.out_e !== 4'h2) begin fails++; $display("FAIL load1_out_e: got %h want 2", d.out_e); end
    drv(3'b001, 4'hF, 16'h0, 1'b0, 1'b0); cyc();
    tests++; if (d.inst_e !== 3'b001) begin fails++; $display("FAIL load2_inst_e: got %b want 001", d.inst_e); end
    tests++; if (d.out_e !== 4'hF) begin fails++; $display("FAIL load2_out_e: got %h want f", d.out_e); end
    drv(3'b001, 4'h5, 16'h0, 1'b0, 1'b0); cyc();
    tests++; if (d.inst_e !== 3'b001) begin fails++; $display("FAIL load3_inst_e: got %b want 001", d.inst_e); end
    tests++; if (d.out_e !== 4'h5) begin fails++; $display("FAIL load3_out_e: got %h want 5", d.out_e); end
    tests++; if (d.valid_s !== 1'b0) begin fails++; $display("FAIL load_valid_s: got %b want 0", d.valid_s); end
  endtask

  task automatic test_ws_exec();
    drv(3'b010, 4'h7, 16'd100, 1'b0, 1'b0); cyc();
    tests++; if (d.out_s !== 16'd114) begin fails++; $display("FAIL ws_exec_out_s: got %h want 0072", d.out_s); end
    tests++; if (d.valid_s !== 1'b1) begin fails++; $display("FAIL ws_exec_valid: got %b want 1", d.valid_s); end
    tests++; if (d.inst_e !== 3'b010) begin fails++; $display("FAIL ws_exec_inst_e: got %b want 010", d.inst_e); end
    drv(3'b000, 4'h0, 16'h0, 1'b0, 1'b0); cyc();
    tests++; if (d.valid_s !== 1'b0) begin fails++; $display("FAIL ws_idle_valid: got %b want 0", d.valid_s); end
    // load+execute together: execute uses resident b=2, load only forwarded
    drv(3'b011, 4'h3, 16'd10, 1'b0, 1'b0); cyc();
    tests++; if (d.out_s !== 16'd16) begin fails++; $display("FAIL ws_ldexec_out_s: got %h want 0010", d.out_s); end
    tests++; if (d.inst_e !== 3'b011) begin fails++; $display("FAIL ws_ldexec_inst_e: got %b want 011", d.inst_e); end
    drv(3'b100, 4'h0, 16'h1234, 1'b0, 1'b1); cyc();
    tests++; if (d.out_s !== 16'h1234 || d.valid_s !== 1'b1) begin fails++; $display("FAIL ws_drain_pass: got %h/%b want 1234/1", d.out_s, d.valid_s); end
    drv(3'b001, 4'hD, 16'h0, 1'b0, 1'b0); cyc();
    drv(3'b010, 4'hF, 16'h0, 1'b0, 1'b0); cyc();
    tests++; if (d.out_s !== 16'hFFD3) begin fails++; $display("FAIL ws_exec_neg: got %h want ffd3", d.out_s); end
    drv(3'b100, 4'h0, 16'h0, 1'b0, 1'b0); cyc();
    tests++; if (d.valid_s !== 1'b0) begin fails++; $display("FAIL ws_drain_novalid: got %b want 0", d.valid_s); end
  endtask

  task automatic test_mode_reload();
    drv(3'b001, 4'h2, 16'h0, 1'b0, 1'b0); cyc();
    drv(3'b000, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
    tests++; if (d.mode_e !== 1'b0) begin fails++; $display("FAIL mode_ignored: got %b want 0", d.mode_e); end
    drv(3'b100, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
    tests++; if (d.mode_e !== 1'b0) begin fails++; $display("FAIL mode_drain: got %b want 0", d.mode_e); end
    drv(3'b010, 4'h5, 16'd10, 1'b0, 1'b0); cyc();
    tests++; if (d.out_s !== 16'd10 || d.valid_s !== 1'b1) begin fails++; $display("FAIL reload_b_cleared: got %h/%b want 000a/1", d.out_s, d.valid_s); end
    drv(3'b000, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
    tests++; if (d.mode_e !== 1'b1) begin fails++; $display("FAIL mode_accept: got %b want 1", d.mode_e); end
  endtask

  task automatic test_os();
    for (int i = 0; i < 4; i++) begin
      drv(3'b010, 4'h3, 16'h0002, 1'b1, 1'b0); cyc();
      tests++; if (d.out_s !== 16'h0002 || d.valid_s !== 1'b0) begin fails++; $display("FAIL os_wfwd_%0d: got %h/%b want 0002/0", i, d.out_s, d.valid_s); end
    end
    drv(3'b100, 4'h0, 16'd55, 1'b1, 1'b1); cyc();
    tests++; if (d.out_s !== 16'd24 || d.valid_s !== 1'b1) begin fails++; $display("FAIL os_drain_own: got %h/%b want 0018/1", d.out_s, d.valid_s); end
    cyc();
    tests++; if (d.out_s !== 16'd55 || d.valid_s !== 1'b1) begin fails++; $display("FAIL os_drain_up: got %h/%b want 0037/1", d.out_s, d.valid_s); end
    drv(3'b000, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
    tests++; if (d.valid_s !== 1'b0) begin fails++; $display("FAIL os_drain_end: got %b want 0", d.valid_s); end
  endtask

  task automatic test_drain_exec();
    drv(3'b010, 4'h3, 16'h0002, 1'b1, 1'b0); cyc();
    drv(3'b110, 4'hF, 16'h0007, 1'b1, 1'b0); cyc();
    tests++; if (d.out_s !== 16'd6 || d.valid_s !== 1'b1) begin fails++; $display("FAIL drain_wins: got %h/%b want 0006/1", d.out_s, d.valid_s); end
    drv(3'b000, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
    drv(3'b010, 4'h1, 16'h0001, 1'b1, 1'b0); cyc();
    drv(3'b100, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
    tests++; if (d.out_s !== 16'd1) begin fails++; $display("FAIL acc_cleared: got %h want 0001", d.out_s); end
    drv(3'b000, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
  endtask

  task automatic test_reset_mid_os();
    for (int i = 0; i < 4; i++) begin
      drv(3'b010, 4'h3, 16'h0002, 1'b1, 1'b0); cyc();
    end
    #2 reset = 1'b0;
    #1;
    tests++; if (d.out_s !== 16'h0 || d.valid_s !== 1'b0) begin fails++; $display("FAIL midrst_out_s: got %h/%b want 0000/0", d.out_s, d.valid_s); end
    tests++; if (d.inst_e !== 3'b000 || d.out_e !== 4'h0) begin fails++; $display("FAIL midrst_east: got %b/%h want 000/0", d.inst_e, d.out_e); end
    @(negedge clk) reset = 1'b1;
    drv(3'b010, 4'h3, 16'h0002, 1'b1, 1'b0); cyc();
    drv(3'b100, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
    tests++; if (d.out_s !== 16'd6 || d.valid_s !== 1'b1) begin fails++; $display("FAIL midrst_restart: got %h/%b want 0006/1", d.out_s, d.valid_s); end
    drv(3'b000, 4'h0, 16'h0, 1'b1, 1'b0); cyc();
  endtask

  task automatic test_saturation();
    drs(3'b001, 4'h7, 8'h0); cyc();
    drs(3'b010, 4'h7, 8'd120); cyc();
    tests++; if (s1.out_s !== 8'h7F) begin fails++; $display("FAIL sat_pos: got %h want 7f", s1.out_s); end
    tests++; if (s0.out_s !== 8'hA9) begin fails++; $display("FAIL wrap_pos: got %h want a9", s0.out_s); end
    drs(3'b100, 4'h0, 8'h0); cyc();
    drs(3'b001, 4'h8, 8'h0); cyc();
    drs(3'b010, 4'hF, 8'h9C); cyc();
    tests++; if (s1.out_s !== 8'h80) begin fails++; $display("FAIL sat_neg: got %h want 80", s1.out_s); end
    tests++; if (s0.out_s !== 8'h24) begin fails++; $display("FAIL wrap_neg: got %h want 24", s0.out_s); end
    drs(3'b000, 4'h0, 8'h0); cyc();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ws_load();
    test_ws_exec();
    test_mode_reload();
    test_os();
    test_drain_exec();
    test_reset_mid_os();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
